// File: rtl/instr_fetch.sv
// instr_fetch: instruction sequencer holding each word for its class-specific cycle count.
// Optional build macro FETCH_JUMP_EN: a class-00 word with bit 17 set jumps instead of halting.
module instr_fetch #(
    parameter int INSTR_WIDTH = 20,
    parameter int ADDR_BITS   = 5,
    parameter int STD_CYC     = 3,
    parameter int LOAD_CYC    = 3,
    parameter int STORE_CYC   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   prog_we,
    input  logic [ADDR_BITS-1:0]   prog_addr,
    input  logic [INSTR_WIDTH-1:0] prog_data,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_BITS-1:0]   pc,
    output logic                   busy,
    output logic                   halted
);
    typedef enum logic [1:0] {IDLE, ISSUE, HALT} state_t;

    localparam logic [3:0] STD_H   = 4'(STD_CYC - 1);
    localparam logic [3:0] LOAD_H  = 4'(LOAD_CYC - 1);
    localparam logic [3:0] STORE_H = 4'(STORE_CYC - 1);

    logic [INSTR_WIDTH-1:0] r_mem [0:(2**ADDR_BITS)-1];
    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic [ADDR_BITS-1:0]   r_pc;
    logic                   r_busy;
    logic                   r_halted;

    logic [ADDR_BITS-1:0]   w_ld_addr;
    logic [ADDR_BITS-1:0]   w_addr;
    logic [INSTR_WIDTH-1:0] w_word;
    logic [INSTR_WIDTH-1:0] w_fetch;
    logic [1:0]             w_cls;
    logic [3:0]             w_hold;
    logic                   w_load;

    assign w_ld_addr = (r_state == ISSUE) ? r_pc : '0;
    assign w_word    = r_mem[w_ld_addr];
`ifdef FETCH_JUMP_EN
    logic w_jump;
    // A jump is resolved inside the fetch; its target is loaded on the same edge.
    assign w_jump  = (w_word[INSTR_WIDTH-1 -: 2] == 2'b00) && w_word[17];
    assign w_addr  = w_jump ? w_word[ADDR_BITS-1:0] : w_ld_addr;
    assign w_fetch = r_mem[w_addr];
`else
    assign w_addr  = w_ld_addr;
    assign w_fetch = w_word;
`endif
    assign w_cls  = w_fetch[INSTR_WIDTH-1 -: 2];
    assign w_hold = (w_cls == 2'b01) ? STD_H : (w_cls == 2'b10) ? LOAD_H : STORE_H;
    assign w_load = (r_state == ISSUE) ? (r_cnt == 4'd0) : start;

    assign instr  = r_instr;
    assign pc     = r_pc;
    assign busy   = r_busy;
    assign halted = r_halted;

    // Program memory write port; a same-edge fetch sees the old word.
    always_ff @(posedge clk) begin
        if (prog_we) r_mem[prog_addr] <= prog_data;
    end

    // Sequencer: load a word, count down its hold, halt on class 00.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_instr  <= '0;
            r_pc     <= '0;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
        end else if (w_load) begin
            if (w_cls == 2'b00) begin
                r_state  <= HALT;
                r_instr  <= '0;
                r_pc     <= w_addr;
                r_cnt    <= '0;
                r_busy   <= 1'b0;
                r_halted <= 1'b1;
            end else begin
                r_state  <= ISSUE;
                r_instr  <= w_fetch;
                r_pc     <= w_addr + 1'b1;
                r_cnt    <= w_hold;
                r_busy   <= 1'b1;
                r_halted <= 1'b0;
            end
        end else if (r_state == ISSUE) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end
endmodule
